// File: rtl/oflow_bbox_packer.sv
`default_nettype none
// ============================================================================
//  Module      : oflow_bbox_packer
//  Description : Producer side of the 89-bit bbox vector used by feature
//                extraction. Packs per-object detection fields, buffers them
//                in a DEPTH-entry FIFO and counts bboxes popped per frame.
//                Optional macro BBOX_CLIP_EN clips width/height to the frame.
//  Revision    : 1.0 - initial release
// ============================================================================
module oflow_bbox_packer #(
    parameter int DEPTH   = 4,
    parameter int FRAME_W = 1280,
    parameter int FRAME_H = 720,
    parameter int CNT_W   = 8
) (
    input  logic                       clk,
    input  logic                       reset_N,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [10:0]                x_tl,
    input  logic [10:0]                y_tl,
    input  logic [7:0]                 width,
    input  logic [7:0]                 height,
    input  logic [23:0]                color1,
    input  logic [23:0]                color2,
    input  logic [2:0]                 d_history,
    input  logic                       frame_start,
    output logic [88:0]                bbox,
    output logic                       bbox_valid,
    input  logic                       bbox_ready,
    output logic [$clog2(DEPTH+1)-1:0] fifo_count,
    output logic [CNT_W-1:0]           frame_bbox_cnt
);

    localparam int              c_PTR_W   = $clog2(DEPTH);
    localparam int              c_CNT_FW  = $clog2(DEPTH+1);
    localparam int              c_BBOX_W  = 89;
    localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};
    localparam logic [c_CNT_FW-1:0] c_FULL = c_CNT_FW'(DEPTH);

    logic [c_BBOX_W-1:0] r_mem [DEPTH];
    logic [c_PTR_W-1:0]  r_wr_ptr;
    logic [c_PTR_W-1:0]  r_rd_ptr;
    logic [c_CNT_FW-1:0] r_count;
    logic [CNT_W-1:0]    r_frame_cnt;

    logic                w_push;
    logic                w_pop;
    logic [7:0]          w_width_pk;
    logic [7:0]          w_height_pk;
    logic [c_BBOX_W-1:0] w_packed;

`ifdef BBOX_CLIP_EN
    localparam logic [11:0] c_FRAME_W = 12'(FRAME_W);
    localparam logic [11:0] c_FRAME_H = 12'(FRAME_H);
    localparam logic [11:0] c_X_LAST  = 12'(FRAME_W - 1);
    localparam logic [11:0] c_Y_LAST  = 12'(FRAME_H - 1);

    logic [11:0] w_x_room;
    logic [11:0] w_y_room;

    // Clip width/height so the box never extends past the last frame pixel
    always_comb begin
        w_x_room = c_X_LAST - {1'b0, x_tl};
        w_y_room = c_Y_LAST - {1'b0, y_tl};
        if ({1'b0, x_tl} >= c_FRAME_W) begin
            w_width_pk = 8'd0;
        end else if ({4'd0, width} > w_x_room) begin
            // room is smaller than an 8-bit width here, so it fits 8 bits
            w_width_pk = w_x_room[7:0];
        end else begin
            w_width_pk = width;
        end
        if ({1'b0, y_tl} >= c_FRAME_H) begin
            w_height_pk = 8'd0;
        end else if ({4'd0, height} > w_y_room) begin
            w_height_pk = w_y_room[7:0];
        end else begin
            w_height_pk = height;
        end
    end
`else
    // Frame geometry only matters when clipping is built in
    logic w_unused_frame_cfg;
    assign w_unused_frame_cfg = FRAME_W[0] ^ FRAME_H[0];
    assign w_width_pk  = width;
    assign w_height_pk = height;
`endif

    assign w_packed = {x_tl, y_tl, w_width_pk, w_height_pk, color1, color2, d_history};

    // Handshake status comes from occupancy alone, never from bbox_ready
    assign in_ready       = (r_count != c_FULL);
    assign bbox_valid     = (r_count != '0);
    assign w_push         = in_valid & in_ready;
    assign w_pop          = bbox_valid & bbox_ready;
    assign bbox           = r_mem[r_rd_ptr];
    assign fifo_count     = r_count;
    assign frame_bbox_cnt = r_frame_cnt;

    // Storage entries, each written only when the write pointer selects it
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            // Entry register; cleared on reset so bbox reads 0 afterwards
            always_ff @(posedge clk or negedge reset_N) begin
                if (!reset_N) begin
                    r_mem[gi] <= '0;
                end else if (w_push && (r_wr_ptr == c_PTR_W'(gi))) begin
                    r_mem[gi] <= w_packed;
                end
            end
        end
    endgenerate

    // Pointer and occupancy bookkeeping; power-of-two depth wraps naturally
    always_ff @(posedge clk or negedge reset_N) begin
        if (!reset_N) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Per-frame pop counter: frame_start restarts it, counting a same-cycle pop
    always_ff @(posedge clk or negedge reset_N) begin
        if (!reset_N) begin
            r_frame_cnt <= '0;
        end else if (frame_start) begin
            r_frame_cnt <= w_pop ? CNT_W'(1) : '0;
        end else if (w_pop && (r_frame_cnt != c_CNT_MAX)) begin
            r_frame_cnt <= r_frame_cnt + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_oflow_bbox_packer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_oflow_bbox_packer
//  Description : Self-checking bench for oflow_bbox_packer: vector table,
//                directed multi-cycle sequences and a randomized run against
//                a queue-based reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_oflow_bbox_packer;

    localparam int c_DEPTH   = 4;
    localparam int c_FRAME_W = 1280;
    localparam int c_FRAME_H = 720;
`ifdef BBOX_CLIP_EN
    localparam bit c_CLIP = 1'b1;
`else
    localparam bit c_CLIP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_N = 1'b0;
    logic        in_valid = 1'b0;
    logic [10:0] x_tl = '0;
    logic [10:0] y_tl = '0;
    logic [7:0]  width = '0;
    logic [7:0]  height = '0;
    logic [23:0] color1 = '0;
    logic [23:0] color2 = '0;
    logic [2:0]  d_history = '0;
    logic        frame_start = 1'b0;
    logic        bbox_ready = 1'b0;

    logic        in_ready, in_ready2;
    logic [88:0] bbox, bbox2;
    logic        bbox_valid, bbox_valid2;
    logic [2:0]  fifo_count, fifo_count2;
    logic [7:0]  frame_bbox_cnt;
    logic [1:0]  frame_bbox_cnt2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    oflow_bbox_packer #(.DEPTH(c_DEPTH), .FRAME_W(c_FRAME_W), .FRAME_H(c_FRAME_H), .CNT_W(8)) u_dut (
        .clk(clk), .reset_N(reset_N), .in_valid(in_valid), .in_ready(in_ready),
        .x_tl(x_tl), .y_tl(y_tl), .width(width), .height(height),
        .color1(color1), .color2(color2), .d_history(d_history),
        .frame_start(frame_start), .bbox(bbox), .bbox_valid(bbox_valid),
        .bbox_ready(bbox_ready), .fifo_count(fifo_count), .frame_bbox_cnt(frame_bbox_cnt)
    );

    // Second instance with a 2-bit frame counter to exercise saturation
    oflow_bbox_packer #(.DEPTH(c_DEPTH), .FRAME_W(c_FRAME_W), .FRAME_H(c_FRAME_H), .CNT_W(2)) u_dut2 (
        .clk(clk), .reset_N(reset_N), .in_valid(in_valid), .in_ready(in_ready2),
        .x_tl(x_tl), .y_tl(y_tl), .width(width), .height(height),
        .color1(color1), .color2(color2), .d_history(d_history),
        .frame_start(frame_start), .bbox(bbox2), .bbox_valid(bbox_valid2),
        .bbox_ready(bbox_ready), .fifo_count(fifo_count2), .frame_bbox_cnt(frame_bbox_cnt2)
    );

    typedef struct {
        logic [10:0] x;
        logic [10:0] y;
        logic [7:0]  w;
        logic [7:0]  h;
        logic [23:0] c1;
        logic [23:0] c2;
        logic [2:0]  d;
        logic [88:0] exp_bbox;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input logic [88:0] act, input logic [88:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        in_valid = 1'b0; bbox_ready = 1'b0; frame_start = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset_N = 1'b0;
        step();
        step();
        reset_N = 1'b1;
        step();
    endtask

    task automatic set_fields(input logic [10:0] x, input logic [10:0] y, input logic [7:0] w,
                              input logic [7:0] h, input logic [23:0] c1, input logic [23:0] c2,
                              input logic [2:0] d);
        x_tl = x; y_tl = y; width = w; height = h; color1 = c1; color2 = c2; d_history = d;
    endtask

    // Reference clip rule: width never extends past the last frame pixel
    function automatic logic [7:0] ref_clip(input int pos, input int len, input int frame);
        if (c_CLIP && pos >= frame) return 8'd0;
        if (c_CLIP && len > frame - 1 - pos) return 8'(frame - 1 - pos);
        return 8'(len);
    endfunction

    function automatic logic [88:0] ref_pack(input logic [10:0] x, input logic [10:0] y,
                                             input logic [7:0] w, input logic [7:0] h,
                                             input logic [23:0] c1, input logic [23:0] c2,
                                             input logic [2:0] d);
        return {x, y, ref_clip(int'(x), int'(w), c_FRAME_W),
                ref_clip(int'(y), int'(h), c_FRAME_H), c1, c2, d};
    endfunction

    logic [88:0] model_q[$];
    int          model_cnt;
    int          model_cnt2;
    logic [88:0] tag_q[$];

    initial begin
        // Vector table: hand-derived expected packing
        vecs[0] = '{11'd100, 11'd50, 8'd20, 8'd10, 24'hABCDEF, 24'h123456, 3'd3,
                    {11'd100, 11'd50, 8'd20, 8'd10, 24'hABCDEF, 24'h123456, 3'd3}};
        vecs[1] = '{11'd1270, 11'd0, 8'd30, 8'd4, 24'h000001, 24'hFFFFFF, 3'd7,
                    {11'd1270, 11'd0, (c_CLIP ? 8'd9 : 8'd30), 8'd4, 24'h000001, 24'hFFFFFF, 3'd7}};
        vecs[2] = '{11'd1300, 11'd10, 8'd30, 8'd8, 24'h55AA55, 24'hAA55AA, 3'd0,
                    {11'd1300, 11'd10, (c_CLIP ? 8'd0 : 8'd30), 8'd8, 24'h55AA55, 24'hAA55AA, 3'd0}};
        vecs[3] = '{11'd0, 11'd0, 8'd255, 8'd255, 24'hFFFFFF, 24'h000000, 3'd5,
                    {11'd0, 11'd0, 8'd255, 8'd255, 24'hFFFFFF, 24'h000000, 3'd5}};
        vecs[4] = '{11'd2047, 11'd719, 8'd1, 8'd5, 24'h0F0F0F, 24'hF0F0F0, 3'd1,
                    {11'd2047, 11'd719, (c_CLIP ? 8'd0 : 8'd1), (c_CLIP ? 8'd0 : 8'd5),
                     24'h0F0F0F, 24'hF0F0F0, 3'd1}};

        #2;
        chk("reset_bbox_valid", 89'(bbox_valid), 89'(0));
        chk("reset_in_ready", 89'(in_ready), 89'(1));
        chk("reset_fifo_count", 89'(fifo_count), 89'(0));
        chk("reset_bbox", bbox, 89'(0));
        chk("reset_frame_cnt", 89'(frame_bbox_cnt), 89'(0));
        do_reset();

        // Table-driven single push / pop
        for (int i = 0; i < 5; i++) begin
            set_fields(vecs[i].x, vecs[i].y, vecs[i].w, vecs[i].h, vecs[i].c1, vecs[i].c2, vecs[i].d);
            in_valid = 1'b1;
            step();
            in_valid = 1'b0;
            chk($sformatf("vec%0d_valid", i), 89'(bbox_valid), 89'(1));
            chk($sformatf("vec%0d_bbox", i), bbox, vecs[i].exp_bbox);
            bbox_ready = 1'b1;
            step();
            bbox_ready = 1'b0;
            chk($sformatf("vec%0d_empty", i), 89'(bbox_valid), 89'(0));
        end

        // Fill to full; fifth push must be ignored
        do_reset();
        tag_q.delete();
        for (int i = 0; i < 5; i++) begin
            set_fields(11'(i + 1), 11'(i + 2), 8'(i + 3), 8'(i + 4), 24'(i * 7), 24'(i * 11), 3'(i));
            if (i < 4) tag_q.push_back({11'(i + 1), 11'(i + 2), 8'(i + 3), 8'(i + 4), 24'(i * 7), 24'(i * 11), 3'(i)});
            in_valid = 1'b1;
            step();
        end
        in_valid = 1'b0;
        chk("full_count", 89'(fifo_count), 89'(4));
        chk("full_in_ready", 89'(in_ready), 89'(0));
        chk("full_head_stable", bbox, tag_q[0]);
        // When full, a same-cycle pop does not let the push in
        in_valid = 1'b1; bbox_ready = 1'b1;
        step();
        in_valid = 1'b0;
        chk("full_pop_no_push_count", 89'(fifo_count), 89'(3));
        void'(tag_q.pop_front());
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("drain%0d_bbox", i), bbox, tag_q[i]);
            step();
        end
        bbox_ready = 1'b0;
        chk("drain_empty", 89'(bbox_valid), 89'(0));

        // Continuous streaming of 10 objects with wrap-around
        do_reset();
        in_valid = 1'b1; bbox_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            set_fields(11'(i * 3), 11'(i), 8'(i), 8'(2 * i), 24'(i + 24'h100), 24'(i), 3'(i));
            step();
            chk($sformatf("stream%0d_count", i), 89'(fifo_count), 89'(1));
            chk($sformatf("stream%0d_bbox", i), bbox,
                ref_pack(11'(i * 3), 11'(i), 8'(i), 8'(2 * i), 24'(i + 24'h100), 24'(i), 3'(i)));
        end
        in_valid = 1'b0;
        step();
        bbox_ready = 1'b0;
        chk("stream_cnt", 89'(frame_bbox_cnt), 89'(10));
        chk("stream_cnt_sat", 89'(frame_bbox_cnt2), 89'(3));

        // Frame counter: five pops then frame_start with a sixth pop
        do_reset();
        in_valid = 1'b1; bbox_ready = 1'b1;
        step();
        for (int i = 0; i < 5; i++) step();
        chk("frame_cnt5", 89'(frame_bbox_cnt), 89'(5));
        chk("frame_cnt5_sat", 89'(frame_bbox_cnt2), 89'(3));
        frame_start = 1'b1;
        step();
        chk("frame_start_pop", 89'(frame_bbox_cnt), 89'(1));
        chk("frame_start_pop2", 89'(frame_bbox_cnt2), 89'(1));
        in_valid = 1'b0; bbox_ready = 1'b0;
        step();
        frame_start = 1'b0;
        chk("frame_start_nopop", 89'(frame_bbox_cnt), 89'(0));

        // Asynchronous reset with entries queued
        do_reset();
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_fields(11'(10 + i), 11'(20 + i), 8'd1, 8'd1, 24'hC0FFEE, 24'hBEEF00, 3'(i));
            step();
        end
        in_valid = 1'b0;
        chk("pre_reset_count", 89'(fifo_count), 89'(3));
        reset_N = 1'b0;
        #1;
        chk("async_reset_valid", 89'(bbox_valid), 89'(0));
        chk("async_reset_count", 89'(fifo_count), 89'(0));
        chk("async_reset_bbox", bbox, 89'(0));
        step();
        reset_N = 1'b1;
        step();
        set_fields(11'd77, 11'd88, 8'd9, 8'd6, 24'h111111, 24'h222222, 3'd2);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        chk("post_reset_valid", 89'(bbox_valid), 89'(1));
        chk("post_reset_bbox", bbox,
            {11'd77, 11'd88, 8'd9, 8'd6, 24'h111111, 24'h222222, 3'd2});

        // Randomized run against the queue model
        do_reset();
        model_q.delete();
        model_cnt = 0;
        model_cnt2 = 0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            logic        m_push, m_pop;
            logic [10:0] rx, ry;
            logic [7:0]  rw, rh;
            logic [23:0] rc1, rc2;
            logic [2:0]  rd;
            // outputs reflect the model state before this edge
            chk("rnd_valid", 89'(bbox_valid), 89'(model_q.size() > 0));
            chk("rnd_in_ready", 89'(in_ready), 89'(model_q.size() < c_DEPTH));
            chk("rnd_count", 89'(fifo_count), 89'(model_q.size()));
            chk("rnd_frame_cnt", 89'(frame_bbox_cnt), 89'(model_cnt));
            chk("rnd_frame_cnt2", 89'(frame_bbox_cnt2), 89'(model_cnt2));
            if (model_q.size() > 0) chk("rnd_bbox", bbox, model_q[0]);

            rx  = ($urandom_range(0, 3) == 0) ? 11'($urandom_range(1200, 1300)) : 11'($urandom);
            ry  = ($urandom_range(0, 3) == 0) ? 11'($urandom_range(650, 750)) : 11'($urandom);
            rw  = 8'($urandom); rh = 8'($urandom);
            rc1 = 24'($urandom); rc2 = 24'($urandom); rd = 3'($urandom);
            set_fields(rx, ry, rw, rh, rc1, rc2, rd);
            in_valid    = ($urandom_range(0, 99) < 60);
            bbox_ready  = ($urandom_range(0, 99) < 50);
            frame_start = ($urandom_range(0, 99) < 5);

            m_push = in_valid && (model_q.size() < c_DEPTH);
            m_pop  = bbox_ready && (model_q.size() > 0);
            if (m_pop) void'(model_q.pop_front());
            if (m_push) model_q.push_back(ref_pack(rx, ry, rw, rh, rc1, rc2, rd));
            if (frame_start) begin
                model_cnt  = m_pop ? 1 : 0;
                model_cnt2 = m_pop ? 1 : 0;
            end else if (m_pop) begin
                model_cnt  = (model_cnt < 255) ? model_cnt + 1 : 255;
                model_cnt2 = (model_cnt2 < 3) ? model_cnt2 + 1 : 3;
            end
            step();
        end
        idle_inputs();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
